// File: rtl/seg_word_if.sv
// Result handshake between the word decoder and its consumer.
// The decoder drives the word, its valid flag, the sticky overrun flag and
// the class of the most recently closed frame; the consumer drives ready.
interface seg_word_if;
   logic [1:0] word_code;
   logic       word_valid;
   logic       word_ready;
   logic       overrun;
   logic [1:0] frame_class;

   modport master (
      output word_code,
      output word_valid,
      output overrun,
      output frame_class,
      input  word_ready
   );

   modport slave (
      input  word_code,
      input  word_valid,
      input  overrun,
      input  frame_class,
      output word_ready
   );
endinterface

// File: rtl/seg_word_decoder.sv
// Seven-segment word decoder.
// Scans four active-low digit codes, one digit per cycle, classifies each
// four-cycle frame as BLANK / NOPE / NICE / INVALID, and reports a word once
// it has been seen for STABLE_FRAMES consecutive frames and differs from the
// word last reported. Results leave through a valid/ready handshake.
module seg_word_decoder #(
   parameter int unsigned STABLE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] display1,
   input  logic [6:0] display2,
   input  logic [6:0] display3,
   input  logic [6:0] display4,
   seg_word_if.master word_if
);

   localparam logic [3:0] STAB_MAX  = 4'(STABLE_FRAMES);
   localparam logic [1:0] CLS_BLANK = 2'b00;
   localparam logic [1:0] CLS_NOPE  = 2'b01;
   localparam logic [1:0] CLS_NICE  = 2'b10;
   localparam logic [1:0] CLS_INVAL = 2'b11;
   localparam logic [6:0] SEG_OFF   = 7'b1111111;

   // Exact-match classification of one frame of four digit codes.
   function automatic logic [1:0] classify(input logic [6:0] d1,
                                           input logic [6:0] d2,
                                           input logic [6:0] d3,
                                           input logic [6:0] d4);
      logic [1:0] cls;
      if (d1 == 7'b1101010 && d2 == 7'b0000001 &&
          d3 == 7'b0011000 && d4 == 7'b0110000) begin
         cls = CLS_NOPE;
      end else if (d1 == 7'b1101010 && d2 == 7'b1111001 &&
                   d3 == 7'b0110001 && d4 == 7'b0110000) begin
         cls = CLS_NICE;
      end else if (d1 == SEG_OFF && d2 == SEG_OFF &&
                   d3 == SEG_OFF && d4 == SEG_OFF) begin
         cls = CLS_BLANK;
      end else begin
         cls = CLS_INVAL;
      end
      return cls;
   endfunction

   logic [1:0] r_scan_idx;
   logic [6:0] r_shadow0;
   logic [6:0] r_shadow1;
   logic [6:0] r_shadow2;
   logic [1:0] r_frame_class;
   logic [1:0] r_candidate;
   logic [3:0] r_stab_cnt;
   logic [1:0] r_last_reported;
   logic [1:0] r_word_code;
   logic       r_word_valid;
   logic       r_overrun;

   logic       w_frame_close;
   logic [1:0] w_class;
   logic       w_issue_ok;
   logic       w_issue;
   logic       w_accept;

   // The last digit of a frame is taken live, so the class is ready on the
   // closing edge itself rather than one cycle later.
   assign w_frame_close = (r_scan_idx == 2'd3);
   assign w_class       = classify(r_shadow0, r_shadow1, r_shadow2, display4);
   assign w_issue_ok    = (r_stab_cnt == STAB_MAX) && (r_candidate != r_last_reported);
   assign w_issue       = w_issue_ok && !r_word_valid;
   assign w_accept      = r_word_valid && word_if.word_ready;

   // Free-running digit scan and capture of digits 1..3 into shadows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_idx <= 2'd0;
         r_shadow0  <= SEG_OFF;
         r_shadow1  <= SEG_OFF;
         r_shadow2  <= SEG_OFF;
      end else begin
         r_scan_idx <= r_scan_idx + 2'd1;
         case (r_scan_idx)
            2'd0:    r_shadow0 <= display1;
            2'd1:    r_shadow1 <= display2;
            2'd2:    r_shadow2 <= display3;
            default: r_shadow0 <= r_shadow0;
         endcase
      end
   end

   // Frame classification and stability counting on each closing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_class <= CLS_BLANK;
         r_candidate   <= CLS_BLANK;
         r_stab_cnt    <= 4'd0;
      end else if (w_frame_close) begin
         r_frame_class <= w_class;
         if (w_class == r_candidate) begin
            if (r_stab_cnt < STAB_MAX) begin
               r_stab_cnt <= r_stab_cnt + 4'd1;
            end
         end else begin
            r_candidate <= w_class;
            r_stab_cnt  <= 4'd1;
         end
      end
   end

   // Result issue, hold until accepted, and sticky overrun detection.
   // A word stable while the previous one is still pending waits here: the
   // issue condition stays true and fires once word_valid has dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_code     <= CLS_BLANK;
         r_word_valid    <= 1'b0;
         r_last_reported <= CLS_BLANK;
         r_overrun       <= 1'b0;
      end else begin
         if (w_issue) begin
            r_word_code     <= r_candidate;
            r_word_valid    <= 1'b1;
            r_last_reported <= r_candidate;
         end else if (w_accept) begin
            r_word_valid <= 1'b0;
         end
         if (w_issue_ok && r_word_valid) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign word_if.word_code   = r_word_code;
   assign word_if.word_valid  = r_word_valid;
   assign word_if.overrun     = r_overrun;
   assign word_if.frame_class = r_frame_class;

endmodule
